// File: rtl/gamepad_reader_if.sv
// Control, status and pad-wire bundle shared by the gamepad reader and its host.
// The slave side is the reader; the master side is the host plus the pad wiring.
interface gamepad_reader_if;
  logic       ena;
  logic       start;
  logic       pad_data_a;
  logic       pad_data_b;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons_a;
  logic [7:0] buttons_b;
  logic       valid;
  logic       busy;

  modport master (
    output ena, start, pad_data_a, pad_data_b,
    input  pad_latch, pad_clk, buttons_a, buttons_b, valid, busy
  );

  modport slave (
    input  ena, start, pad_data_a, pad_data_b,
    output pad_latch, pad_clk, buttons_a, buttons_b, valid, busy
  );
endinterface

// File: rtl/gamepad_reader.sv
// Polls two shift-register gamepads in lockstep: latch pulse, then 8 serial bits per pad.
// A poll takes 17*CLK_DIV+1 cycles after start; buttons/valid update in the final cycle.
module gamepad_reader #(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  gamepad_reader_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, LATCH, HIGH, LOW, DONE} state_e;

  localparam logic [8:0] LATCH_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] PHASE_LAST = 9'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [1:0] sync_a_q, sync_a_d;
  logic [1:0] sync_b_q, sync_b_d;
  logic [7:0] sr_a_q, sr_a_d;
  logic [7:0] sr_b_q, sr_b_d;
  logic [7:0] btn_a_q, btn_a_d;
  logic [7:0] btn_b_q, btn_b_d;
  logic       latch_q, latch_d;
  logic       pclk_q, pclk_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sr_a_d   = sr_a_q;
    sr_b_d   = sr_b_q;
    btn_a_d  = btn_a_q;
    btn_b_d  = btn_b_q;
    latch_d  = 1'b0;
    pclk_d   = 1'b1;
    valid_d  = 1'b0;
    sync_a_d = {sync_a_q[0], bus.pad_data_a};
    sync_b_d = {sync_b_q[0], bus.pad_data_b};

    case (state_q)
      IDLE: begin
        if (bus.start && bus.ena) begin
          state_d = LATCH;
          cnt_d   = '0;
          latch_d = 1'b1;
        end
      end
      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          latch_d = 1'b1;
          cnt_d   = cnt_q + 9'd1;
        end
      end
      HIGH: begin
        if (cnt_q == PHASE_LAST) begin
          cnt_d          = '0;
          sr_a_d[idx_q]  = ~sync_a_q[1];
          sr_b_d[idx_q]  = ~sync_b_q[1];
          if (idx_q == 3'd7) begin
            // Commit both pads together so the host never sees a half-updated pair.
            state_d = DONE;
            btn_a_d = sr_a_d;
            btn_b_d = sr_b_d;
            valid_d = 1'b1;
          end else begin
            state_d = LOW;
            pclk_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      LOW: begin
        if (cnt_q == PHASE_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
        end else begin
          pclk_d = 1'b0;
          cnt_d  = cnt_q + 9'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Dropping ena abandons the poll; the last committed buttons stay visible.
    if (!bus.ena && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      sr_a_d  = '0;
      sr_b_d  = '0;
      btn_a_d = btn_a_q;
      btn_b_d = btn_b_q;
      latch_d = 1'b0;
      pclk_d  = 1'b1;
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sync_a_q <= 2'b11;
      sync_b_q <= 2'b11;
      sr_a_q   <= '0;
      sr_b_q   <= '0;
      btn_a_q  <= '0;
      btn_b_q  <= '0;
      latch_q  <= 1'b0;
      pclk_q   <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
      sr_a_q   <= sr_a_d;
      sr_b_q   <= sr_b_d;
      btn_a_q  <= btn_a_d;
      btn_b_q  <= btn_b_d;
      latch_q  <= latch_d;
      pclk_q   <= pclk_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.pad_latch = latch_q;
  assign bus.pad_clk   = pclk_q;
  assign bus.buttons_a = btn_a_q;
  assign bus.buttons_b = btn_b_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/gamepad_reader.md
GAMEPAD_READER -- requirements
Module: gamepad_reader

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pad half-bit phase; legal range 4..255.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ena  input  1  block enable; low forces idle.
REQ-005 start  input  1  poll request, sampled in IDLE only, typically a once-per-frame pulse.
REQ-006 pad_data_a  input  1  serial data from pad A, active-low (0 = pressed).
REQ-007 pad_data_b  input  1  serial data from pad B, active-low.
REQ-008 pad_latch  output  1  parallel-load strobe to both pads, active-high, registered.
REQ-009 pad_clk  output  1  shift clock to both pads, idle high, registered; pads shift on its rising edge.
REQ-010 buttons_a  output  8  pad A state, active-high: bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-011 buttons_b  output  8  pad B state, same bit map.
REQ-012 valid  output  1  one-cycle pulse when buttons_a/b have just updated.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, LATCH, HIGH, LOW, DONE; a phase counter counts CLK_DIV cycles per phase and a 3-bit bit index counts 0..7.
REQ-015 IDLE: pad_latch=0, pad_clk=1, busy=0; start=1 and ena=1 in a cycle (cycle 0) -> LATCH.
REQ-016 LATCH: pad_latch=1, pad_clk=1 for cycles 1..2*CLK_DIV; then HIGH with bit index 0.
REQ-017 HIGH: pad_latch=0, pad_clk=1 for CLK_DIV cycles; on the clock edge ending the phase, the inverted synchronized pad_data_a/b are stored into bit <index> of internal shift registers.
REQ-018 After a HIGH phase with index <7 -> LOW; with index 7 -> DONE.
REQ-019 LOW: pad_clk=0 for CLK_DIV cycles; then index increments and -> HIGH (rising pad_clk).
REQ-020 Bit 7 sample edge ends cycle 17*CLK_DIV; DONE occupies cycle 17*CLK_DIV+1: buttons_a/b load both shift registers simultaneously, valid=1 for exactly that cycle; then IDLE.
REQ-021 Per poll: exactly one pad_latch pulse of 2*CLK_DIV cycles, exactly 7 pad_clk low pulses of CLK_DIV cycles each.
REQ-022 pad_data_a/b each pass through a 2-flop synchronizer before sampling.
REQ-023 buttons_a/b hold their value between polls; they change only in DONE.
REQ-024 start while busy=1 is ignored, not queued; start held high continuously begins a new poll in the first IDLE cycle after DONE.
REQ-025 start with ena=0 is ignored.
REQ-026 ena deasserted in any non-IDLE state: next cycle IDLE, pad_latch=0, pad_clk=1, no valid, buttons unchanged, partial shift data discarded.
REQ-027 Both pads are read in lockstep; no per-pad state.

Reset
REQ-028 rst_n=0 asynchronously forces: state IDLE, pad_latch=0, pad_clk=1, buttons_a=0, buttons_b=0, valid=0, busy=0, counters and synchronizers 0/1 (synchronizers reset to 1 = released).
REQ-029 Reset mid-poll abandons the poll; after release the block waits in IDLE for a new start.

Verification (CLK_DIV=4; pad models shift on pad_clk rise, load on pad_latch high)
REQ-030 Pad A pressed=A+Right (0x81), pad B pressed=Start (0x08), one start pulse -> pad_latch high cycles 1..8, valid at cycle 69 only, buttons_a=0x81, buttons_b=0x08, busy low from cycle 70.
REQ-031 Both pads all released (data constantly 1) -> buttons_a=buttons_b=0x00 with valid; all pressed (data 0) -> 0xFF/0xFF.
REQ-032 Count pad_clk edges per poll -> exactly 7 falling, 7 rising; low pulses 4 cycles each; no pad_clk activity while pad_latch=1.
REQ-033 Second start pulses at cycles 10 and 40 of a poll -> ignored; only one valid; start held high 200 cycles -> consecutive polls, valid pulses 70 cycles apart.
REQ-034 ena dropped at cycle 30 -> pad_latch=0, pad_clk=1, busy=0 next cycle, no valid, buttons keep prior 0x81/0x08.
REQ-035 rst_n pulsed low at cycle 45 -> outputs immediately at reset values, buttons 0x00; fresh start after release completes normally in 69 cycles.
